// File: rtl/config_responder.sv
// Chip-side packet responder: decodes 64-bit UART config packets,
// drives regmap write/read strobes and builds the odd-parity reply.
module config_responder #(
   parameter int         WIDTH     = 64,
   parameter int         REGNUM    = 256,
   parameter logic [7:0] GLOBAL_ID = 8'd255,
   parameter int         CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           chip_id,
   input  logic                 rx_valid,
   input  logic [WIDTH-2:0]     rx_data,
   input  logic                 parity_error,
   output logic                 uld_rx_data,
   output logic                 regmap_we,
   output logic                 regmap_re,
   output logic [7:0]           regmap_addr,
   output logic [7:0]           regmap_wdata,
   input  logic [7:0]           regmap_rdata,
   output logic [WIDTH-1:0]     tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] parity_err_cnt,
   output logic [CNT_WIDTH-1:0] drop_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_WRITE,
      S_READ,
      S_READ_WAIT,
      S_REPLY
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                 r_state;
   logic [1:0]             r_type;
   logic [7:0]             r_id;
   logic [7:0]             r_addr;
   logic [7:0]             r_wdata;
   logic [7:0]             r_data;
   logic                   r_perr;
   logic                   r_uld;
   logic                   r_we;
   logic                   r_re;
   logic [WIDTH-1:0]       r_tx_data;
   logic                   r_tx_valid;
   logic [CNT_WIDTH-1:0]   r_perr_cnt;
   logic [CNT_WIDTH-1:0]   r_drop_cnt;

   logic                   w_addr_ok;
   logic                   w_foreign;
   logic [WIDTH-2:0]       w_body;
   logic [WIDTH-1:0]       w_reply;
   logic                   w_unused;

   assign w_addr_ok = (32'(r_addr) < 32'(REGNUM));
   assign w_foreign = (r_id != chip_id) && (r_id != GLOBAL_ID);

   // Reply always carries our own ID, even when answering a broadcast
   assign w_body  = {1'b1, {(WIDTH-28){1'b0}}, r_data, r_addr, chip_id, r_type};
   assign w_reply = {~^w_body, w_body};

   assign w_unused = ^rx_data[WIDTH-2:26];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_type     <= '0;
         r_id       <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_data     <= '0;
         r_perr     <= 1'b0;
         r_uld      <= 1'b0;
         r_we       <= 1'b0;
         r_re       <= 1'b0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_perr_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_uld <= 1'b0;
         r_we  <= 1'b0;
         r_re  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (rx_valid) begin
                  r_type  <= rx_data[1:0];
                  r_id    <= rx_data[9:2];
                  r_addr  <= rx_data[17:10];
                  r_wdata <= rx_data[25:18];
                  r_perr  <= parity_error;
                  r_uld   <= 1'b1;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (r_perr) begin
                  if (r_perr_cnt != '1)
                     r_perr_cnt <= r_perr_cnt + CNT_ONE;
                  r_state <= S_IDLE;
               end else if (!r_type[1] || w_foreign) begin
                  if (r_drop_cnt != '1)
                     r_drop_cnt <= r_drop_cnt + CNT_ONE;
                  r_state <= S_IDLE;
               end else if (r_type[0]) begin
                  r_re    <= w_addr_ok;
                  r_state <= S_READ;
               end else begin
                  r_we    <= w_addr_ok;
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_data  <= r_wdata;
               r_state <= S_REPLY;
            end
            S_READ: begin
               r_state <= S_READ_WAIT;
            end
            S_READ_WAIT: begin
               r_data  <= w_addr_ok ? regmap_rdata : 8'h00;
               r_state <= S_REPLY;
            end
            S_REPLY: begin
               // First cycle loads the reply, then hold until accepted
               if (!r_tx_valid) begin
                  r_tx_data  <= w_reply;
                  r_tx_valid <= 1'b1;
               end else if (tx_ready) begin
                  r_tx_valid <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign uld_rx_data    = r_uld;
   assign regmap_we      = r_we;
   assign regmap_re      = r_re;
   assign regmap_addr    = r_addr;
   assign regmap_wdata   = r_wdata;
   assign tx_data        = r_tx_data;
   assign tx_valid       = r_tx_valid;
   assign busy           = (r_state != S_IDLE);
   assign parity_err_cnt = r_perr_cnt;
   assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_config_responder.sv
// Bench for config_responder: vector table, random packets against
// a packet-level model, backpressure, counter saturation and reset abort.
module tb_config_responder;

   localparam logic [7:0] CHIP = 8'd16;
   localparam int         REGN = 250;

   logic        clk;
   logic        reset;
   logic [7:0]  chip_id;
   logic        rx_valid;
   logic [62:0] rx_data;
   logic        parity_error;
   logic        uld_rx_data;
   logic        regmap_we;
   logic        regmap_re;
   logic [7:0]  regmap_addr;
   logic [7:0]  regmap_wdata;
   logic [7:0]  regmap_rdata;
   logic [63:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic [7:0]  parity_err_cnt;
   logic [7:0]  drop_cnt;

   config_responder #(
      .WIDTH(64), .REGNUM(REGN), .GLOBAL_ID(8'd255), .CNT_WIDTH(8)
   ) dut (
      .clk(clk), .reset(reset), .chip_id(chip_id),
      .rx_valid(rx_valid), .rx_data(rx_data), .parity_error(parity_error),
      .uld_rx_data(uld_rx_data), .regmap_we(regmap_we), .regmap_re(regmap_re),
      .regmap_addr(regmap_addr), .regmap_wdata(regmap_wdata),
      .regmap_rdata(regmap_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .parity_err_cnt(parity_err_cnt),
      .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Regmap stand-in: registered read, data valid the cycle after re
   logic [7:0] mem [256];
   logic       mem_init;
   int         n_we = 0;
   int         n_re = 0;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[7]   <= 8'h3C;
         mem[250] <= 8'hEE;
      end else begin
         if (regmap_we) mem[regmap_addr] <= regmap_wdata;
         if (regmap_re) regmap_rdata <= mem[regmap_addr];
      end
   end

   always @(posedge clk) begin
      if (regmap_we) n_we++;
      if (regmap_re) n_re++;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Packet-level reference model
   logic [7:0] ref_mem [256];
   int         exp_perr = 0;
   int         exp_drop = 0;

   function automatic logic [63:0] mk_reply(input logic [1:0] t,
                                            input logic [7:0] a,
                                            input logic [7:0] dv);
      logic [63:0] r;
      r = 64'(t) + 64'(CHIP) * 64'd4 + 64'(a) * 64'd1024
        + 64'(dv) * (64'd1 << 18) + (64'd1 << 62);
      if ($countones(r) % 2 == 0) r = r + (64'd1 << 63);
      return r;
   endfunction

   function automatic logic [62:0] mk_pkt(input logic [1:0] t,
                                          input logic [7:0] id,
                                          input logic [7:0] a,
                                          input logic [7:0] dv,
                                          input logic [36:0] j);
      return {j, dv, a, id, t};
   endfunction

   task automatic model(input logic [1:0] t, input logic [7:0] id,
                        input logic [7:0] a, input logic [7:0] dv,
                        input logic pe, output int kind,
                        output logic [63:0] etx, output int elat,
                        output int ewe, output int ere);
      logic [7:0] rd;
      etx = '0; elat = 0; ewe = 0; ere = 0;
      if (pe) begin
         kind = 2;
         if (exp_perr < 255) exp_perr++;
      end else if (t < 2 || (id != CHIP && id != 8'd255)) begin
         kind = 1;
         if (exp_drop < 255) exp_drop++;
      end else begin
         kind = 0;
         if (t == 2'd2) begin
            if (int'(a) < REGN) begin ref_mem[a] = dv; ewe = 1; end
            etx  = mk_reply(t, a, dv);
            elat = 4;
         end else begin
            rd   = (int'(a) < REGN) ? ref_mem[a] : 8'h00;
            ere  = (int'(a) < REGN) ? 1 : 0;
            etx  = mk_reply(t, a, rd);
            elat = 5;
         end
      end
   endtask

   task automatic present(input logic [62:0] d, input logic pe);
      rx_data = d; parity_error = pe; rx_valid = 1'b1;
   endtask

   // Called at a negedge with the DUT idle and rx_valid high
   task automatic take_uld();
      @(posedge clk); @(negedge clk);
      chk("uld_pulse", 64'(uld_rx_data), 64'd1);
      rx_valid = 1'b0; parity_error = 1'b0;
   endtask

   task automatic finish_pkt(input int kind, input logic [63:0] etx,
                             input int elat, input int ewe, input int ere);
      int n, we0, re0;
      n = 1; we0 = n_we; re0 = n_re;
      while (n < 12) begin
         @(posedge clk); @(negedge clk);
         n++;
         if (n == 2) chk("uld_width", 64'(uld_rx_data), 64'd0);
         if (tx_valid) break;
      end
      if (kind == 0) begin
         if (!tx_valid) begin
            chk("tx_timeout", 64'd0, 64'd1);
         end else begin
            chk("latency", 64'(n), 64'(elat));
            chk("tx_data", tx_data, etx);
            tx_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            tx_ready = 1'b0;
            chk("tx_release", 64'({tx_valid, busy}), 64'd0);
         end
      end else begin
         chk("no_reply", 64'({tx_valid, busy}), 64'd0);
      end
      chk("we_pulses", 64'(n_we - we0), 64'(ewe));
      chk("re_pulses", 64'(n_re - re0), 64'(ere));
   endtask

   task automatic do_pkt(input logic [62:0] d, input logic pe, input int kind,
                         input logic [63:0] etx, input int elat,
                         input int ewe, input int ere);
      present(d, pe);
      take_uld();
      finish_pkt(kind, etx, elat, ewe, ere);
   endtask

   typedef struct {
      logic [1:0] t;
      logic [7:0] id;
      logic [7:0] a;
      logic [7:0] d;
      logic       pe;
      int         kind;
      logic [7:0] rd;
      int         lat;
      int         we;
      int         re;
   } vec_t;

   vec_t tv [16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int          k, el, ew, er, k2, el2, ew2, er2;
      logic [63:0] etx, etx2, snap;
      logic [1:0]  t;
      logic [7:0]  id, a, dv;
      logic        pe, bad;
      logic [36:0] j;
      int          n;

      tv[0]  = '{2'd2, 8'd16,  8'd5,   8'hA5, 1'b0, 0, 8'hA5, 4, 1, 0};
      tv[1]  = '{2'd3, 8'd255, 8'd7,   8'h00, 1'b0, 0, 8'h3C, 5, 0, 1};
      tv[2]  = '{2'd2, 8'd31,  8'd5,   8'h11, 1'b0, 1, 8'h00, 0, 0, 0};
      tv[3]  = '{2'd2, 8'd16,  8'd5,   8'h22, 1'b1, 2, 8'h00, 0, 0, 0};
      tv[4]  = '{2'd0, 8'd16,  8'd5,   8'h33, 1'b0, 1, 8'h00, 0, 0, 0};
      tv[5]  = '{2'd1, 8'd16,  8'd5,   8'h44, 1'b0, 1, 8'h00, 0, 0, 0};
      tv[6]  = '{2'd3, 8'd16,  8'd5,   8'h00, 1'b0, 0, 8'hA5, 5, 0, 1};
      tv[7]  = '{2'd2, 8'd255, 8'd249, 8'h77, 1'b0, 0, 8'h77, 4, 1, 0};
      tv[8]  = '{2'd2, 8'd16,  8'd250, 8'h88, 1'b0, 0, 8'h88, 4, 0, 0};
      tv[9]  = '{2'd3, 8'd16,  8'd250, 8'h00, 1'b0, 0, 8'h00, 5, 0, 0};
      tv[10] = '{2'd3, 8'd16,  8'd249, 8'h00, 1'b0, 0, 8'h77, 5, 0, 1};
      tv[11] = '{2'd3, 8'd31,  8'd7,   8'h00, 1'b1, 2, 8'h00, 0, 0, 0};
      tv[12] = '{2'd0, 8'd16,  8'd7,   8'h00, 1'b1, 2, 8'h00, 0, 0, 0};
      tv[13] = '{2'd3, 8'd0,   8'd7,   8'h00, 1'b0, 1, 8'h00, 0, 0, 0};
      tv[14] = '{2'd3, 8'd255, 8'd255, 8'h00, 1'b0, 0, 8'h00, 5, 0, 0};
      tv[15] = '{2'd2, 8'd16,  8'd0,   8'hFF, 1'b0, 0, 8'hFF, 4, 1, 0};

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      ref_mem[7]   = 8'h3C;
      ref_mem[250] = 8'hEE;

      chip_id = CHIP; rx_valid = 1'b0; rx_data = '0; parity_error = 1'b0;
      tx_ready = 1'b0; reset = 1'b1; mem_init = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes",
          64'({uld_rx_data, regmap_we, regmap_re, tx_valid, busy}), 64'd0);
      chk("rst_tx_data", tx_data, 64'd0);
      chk("rst_counters", 64'({parity_err_cnt, drop_cnt}), 64'd0);
      mem_init = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         j = (i % 2 == 1) ? '1 : '0;
         model(tv[i].t, tv[i].id, tv[i].a, tv[i].d, tv[i].pe,
               k, etx, el, ew, er);
         do_pkt(mk_pkt(tv[i].t, tv[i].id, tv[i].a, tv[i].d, j), tv[i].pe,
                tv[i].kind, mk_reply(tv[i].t, tv[i].a, tv[i].rd),
                tv[i].lat, tv[i].we, tv[i].re);
      end
      chk("tbl_perr_cnt", 64'(parity_err_cnt), 64'd3);
      chk("tbl_drop_cnt", 64'(drop_cnt), 64'd4);

      // Backpressure: reply held while a second packet waits
      model(2'd2, CHIP, 8'd10, 8'h5C, 1'b0, k, etx, el, ew, er);
      present(mk_pkt(2'd2, CHIP, 8'd10, 8'h5C, '0), 1'b0);
      take_uld();
      n = 1;
      while (!tx_valid && n < 12) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      chk("bp_latency", 64'(n), 64'(el));
      chk("bp_tx_data", tx_data, etx);
      snap = tx_data;
      model(2'd3, CHIP, 8'd10, 8'h00, 1'b0, k2, etx2, el2, ew2, er2);
      present(mk_pkt(2'd3, CHIP, 8'd10, 8'h00, '0), 1'b0);
      bad = 1'b0;
      repeat (20) begin
         @(posedge clk); @(negedge clk);
         if (tx_data !== snap || tx_valid !== 1'b1 || uld_rx_data !== 1'b0)
            bad = 1'b1;
      end
      chk("bp_stall", 64'(bad), 64'd0);
      tx_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      tx_ready = 1'b0;
      chk("bp_release", 64'({tx_valid, uld_rx_data}), 64'd0);
      take_uld();
      finish_pkt(k2, etx2, el2, ew2, er2);

      for (int i = 0; i < 120; i++) begin
         t = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0, 3:    id = CHIP;
            1:       id = 8'hFF;
            default: id = 8'($urandom());
         endcase
         a  = ($urandom_range(0, 1) == 1) ? 8'($urandom())
                                          : 8'($urandom_range(245, 255));
         dv = 8'($urandom());
         pe = ($urandom_range(0, 7) == 0);
         j  = 37'({$urandom(), $urandom()});
         model(t, id, a, dv, pe, k, etx, el, ew, er);
         do_pkt(mk_pkt(t, id, a, dv, j), pe, k, etx, el, ew, er);
      end
      chk("rnd_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

      for (int i = 0; i < 300; i++) begin
         model(2'd2, CHIP, 8'd3, 8'h5A, 1'b1, k, etx, el, ew, er);
         do_pkt(mk_pkt(2'd2, CHIP, 8'd3, 8'h5A, '0), 1'b1,
                k, etx, el, ew, er);
      end
      chk("sat_perr_model", 64'(parity_err_cnt), 64'(exp_perr));
      chk("sat_perr_max", 64'(parity_err_cnt), 64'd255);

      // Reset while waiting for read data aborts the packet
      present(mk_pkt(2'd3, CHIP, 8'd7, 8'h00, '0), 1'b0);
      take_uld();
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("abort_strobes",
          64'({uld_rx_data, regmap_we, regmap_re, tx_valid, busy}), 64'd0);
      chk("abort_counters", 64'({parity_err_cnt, drop_cnt}), 64'd0);
      chk("abort_tx_data", tx_data, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_perr = 0;
      exp_drop = 0;
      @(negedge clk);
      model(2'd2, 8'd255, 8'd100, 8'hC3, 1'b0, k, etx, el, ew, er);
      do_pkt(mk_pkt(2'd2, 8'd255, 8'd100, 8'hC3, '0), 1'b0,
             k, etx, el, ew, er);
      model(2'd3, CHIP, 8'd100, 8'h00, 1'b0, k, etx, el, ew, er);
      do_pkt(mk_pkt(2'd3, CHIP, 8'd100, 8'h00, '0), 1'b0,
             k, etx, el, ew, er);
      model(2'd1, CHIP, 8'd1, 8'h00, 1'b0, k, etx, el, ew, er);
      do_pkt(mk_pkt(2'd1, CHIP, 8'd1, 8'h00, '0), 1'b0,
             k, etx, el, ew, er);
      chk("post_reset_cnt", 64'({parity_err_cnt, drop_cnt}),
          64'({8'(exp_perr), 8'(exp_drop)}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
